div_seq: RTL



---
 rtl/div_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU.
// Produces one quotient bit per cycle and returns {remainder, quotient} with sign correction.
module div_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    signed_div_i,
    input  logic [DATA_WIDTH-1:0]   opdata1_i,
    input  logic [DATA_WIDTH-1:0]   opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [2*DATA_WIDTH-1:0] result_o,
    output logic                    ready_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   rem, quo, dvs;
    logic           neg_q, neg_r;

    logic [W-1:0]   mag1, mag2;
    logic [W:0]     r_sh;
    logic [W+1:0]   trial;
    logic           borrow;
    logic [W-1:0]   rem_nxt, quo_nxt, rem_fix, quo_fix;
    logic           last, accept, abort;

    always_comb begin
        mag1    = (signed_div_i && opdata1_i[W-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[W-1]) ? -opdata2_i : opdata2_i;
        // Shift the next dividend bit into the partial remainder, then trial-subtract;
        // the extra top bit of the trial is the borrow.
        r_sh    = {rem, quo[W-1]};
        trial   = {1'b0, r_sh} - {2'b00, dvs};
        borrow  = trial[W+1];
        rem_nxt = borrow ? r_sh[W-1:0] : trial[W-1:0];
        quo_nxt = {quo[W-2:0], ~borrow};
        rem_fix = neg_r ? -rem_nxt : rem_nxt;
        quo_fix = neg_q ? -quo_nxt : quo_nxt;
        last    = (cnt == CW'(W-1));
        accept  = start_i && !annul_i;
        abort   = annul_i || !start_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_nxt = END;
            ON:      if (abort) state_nxt = IDLE;
                     else if (last) state_nxt = END;
            END:     if (!start_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept && opdata2_i != '0) begin
                        rem   <= '0;
                        quo   <= mag1;
                        dvs   <= mag2;
                        cnt   <= '0;
                        neg_q <= signed_div_i && (opdata1_i[W-1] ^ opdata2_i[W-1]);
                        neg_r <= signed_div_i && opdata1_i[W-1];
                    end
                end
                BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ON: begin
                    if (!abort) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
